// File: rtl/fft_frame_reader.sv
// Read-side sequencer for the I2S double buffer. On each frame-ready edge it walks
// the buffer read address 0..DEPTH-1 and streams the samples to the FFT over a
// valid/ready link. A 2-entry skid buffer absorbs the one-cycle RAM read latency,
// so a stalled consumer never loses or duplicates a sample.
module fft_frame_reader #(
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = 9,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_enable,
  input  logic                  i_buf_ready,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic [DATA_WIDTH-1:0] o_m_data,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic                  o_m_sof,
  output logic                  o_m_eof,
  output logic                  o_busy,
  output logic                  o_overrun,
  output logic [CNT_WIDTH-1:0]  o_frame_cnt,
  output logic [CNT_WIDTH-1:0]  o_drop_cnt
);

  // state  | meaning
  // IDLE   | waiting for a frame-ready edge, read address parked at 0
  // STREAM | issuing one read per cycle while the skid buffer has room
  // DRAIN  | last address issued, waiting for the eof beat to be accepted
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                  state;
  logic                    buf_ready_q;
  logic                    armed;
  logic                    rd_pending;
  logic                    pend_sof;
  logic                    pend_eof;
  logic                    sk_valid;
  logic                    sk_sof;
  logic                    sk_eof;
  logic [DATA_WIDTH-1:0]   sk_data;
  logic                    frame_event;
  logic                    accept;
  logic                    credit;
  logic                    issue;
  logic [1:0]              occupancy;

  // A level already high when reset releases must not count as an edge,
  // so the detector is only armed once the input has been seen low.
  assign frame_event = i_buf_ready & ~buf_ready_q & armed;
  assign accept      = o_m_valid & i_m_ready;
  // Occupancy counts buffered samples plus the read in flight; the beat leaving
  // this cycle frees its slot early so a steady stream has no bubbles.
  assign occupancy   = {1'b0, o_m_valid} + {1'b0, sk_valid} + {1'b0, rd_pending};
  assign credit      = (occupancy - {1'b0, accept}) < 2'd2;
  assign issue       = (state == STREAM) & credit;
  assign o_busy      = (state != IDLE);

  // Frame-ready edge detector
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_ready_q <= 1'b0;
      armed       <= ~i_buf_ready;
    end else begin
      buf_ready_q <= i_buf_ready;
      armed       <= armed | ~i_buf_ready;
    end
  end

  // Sequencer FSM: address walk, read tagging, frame/drop/overrun bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      o_rd_addr   <= '0;
      rd_pending  <= 1'b0;
      pend_sof    <= 1'b0;
      pend_eof    <= 1'b0;
      o_overrun   <= 1'b0;
      o_frame_cnt <= '0;
      o_drop_cnt  <= '0;
    end else begin
      rd_pending <= issue;
      if (issue) begin
        pend_sof <= (o_rd_addr == '0);
        pend_eof <= (o_rd_addr == LAST_ADDR);
      end
      if (frame_event && (state != IDLE || !i_enable))
        o_drop_cnt <= o_drop_cnt + 1'b1;
      if (frame_event && state != IDLE)
        o_overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (frame_event && i_enable) begin
            state     <= STREAM;
            o_rd_addr <= '0;
          end
        end
        STREAM: begin
          if (issue) begin
            if (o_rd_addr == LAST_ADDR) state <= DRAIN;
            else                        o_rd_addr <= o_rd_addr + 1'b1;
          end
        end
        DRAIN: begin
          if (accept && o_m_eof) begin
            state       <= IDLE;
            o_rd_addr   <= '0;
            o_frame_cnt <= o_frame_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register plus one spare slot; the head holds steady while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      o_m_valid <= 1'b0;
      o_m_data  <= '0;
      o_m_sof   <= 1'b0;
      o_m_eof   <= 1'b0;
      sk_valid  <= 1'b0;
      sk_data   <= '0;
      sk_sof    <= 1'b0;
      sk_eof    <= 1'b0;
    end else if (!o_m_valid || i_m_ready) begin
      if (sk_valid) begin
        o_m_valid <= 1'b1;
        o_m_data  <= sk_data;
        o_m_sof   <= sk_sof;
        o_m_eof   <= sk_eof;
        sk_valid  <= rd_pending;
        if (rd_pending) begin
          sk_data <= i_rd_data;
          sk_sof  <= pend_sof;
          sk_eof  <= pend_eof;
        end
      end else begin
        o_m_valid <= rd_pending;
        if (rd_pending) begin
          o_m_data <= i_rd_data;
          o_m_sof  <= pend_sof;
          o_m_eof  <= pend_eof;
        end
      end
    end else if (rd_pending) begin
      sk_valid <= 1'b1;
      sk_data  <= i_rd_data;
      sk_sof   <= pend_sof;
      sk_eof   <= pend_eof;
    end
  end

endmodule

// File: tb/tb_fft_frame_reader.sv
// Bench for fft_frame_reader: RAM model returns {salt, addr}; the reference model
// expects each frame as the plain index sequence 0..DEPTH-1 with sof/eof on the ends.
module tb_fft_frame_reader;
  localparam int DW    = 24;
  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int CW    = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_enable;
  logic          i_buf_ready;
  logic [AW-1:0] o_rd_addr;
  logic [DW-1:0] i_rd_data;
  logic [DW-1:0] o_m_data;
  logic          o_m_valid;
  logic          i_m_ready;
  logic          o_m_sof;
  logic          o_m_eof;
  logic          o_busy;
  logic          o_overrun;
  logic [CW-1:0] o_frame_cnt;
  logic [CW-1:0] o_drop_cnt;

  int vectors     = 0;
  int miscompares = 0;

  logic [14:0]   salt = 15'h0;
  bit            rnd_ready = 1'b0;
  int            beat_idx = 0;
  int            beats_seen = 0;
  bit            hold_pending = 1'b0;
  logic [DW+1:0] held = '0;

  always #5 clk = ~clk;

  fft_frame_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .i_enable(i_enable), .i_buf_ready(i_buf_ready),
    .o_rd_addr(o_rd_addr), .i_rd_data(i_rd_data), .o_m_data(o_m_data),
    .o_m_valid(o_m_valid), .i_m_ready(i_m_ready), .o_m_sof(o_m_sof), .o_m_eof(o_m_eof),
    .o_busy(o_busy), .o_overrun(o_overrun), .o_frame_cnt(o_frame_cnt), .o_drop_cnt(o_drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // RAM with one cycle of read latency
  always @(posedge clk) i_rd_data <= {salt, o_rd_addr};

  // Consumer ready: constant 1 or 50% random
  initial begin
    i_m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 i_m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Stream monitor against the index-sequence model
  always @(negedge clk) begin
    if (reset) begin
      beat_idx     = 0;
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        chk("stall_valid", o_m_valid, 1);
        chk("stall_hold", {o_m_data, o_m_sof, o_m_eof}, held);
      end
      hold_pending = 1'b0;
      if (o_m_valid) begin
        if (i_m_ready) begin
          chk("beat_data", o_m_data, {salt, beat_idx[AW-1:0]});
          chk("beat_sof", o_m_sof, beat_idx == 0);
          chk("beat_eof", o_m_eof, beat_idx == DEPTH - 1);
          beats_seen++;
          beat_idx = (beat_idx == DEPTH - 1) ? 0 : beat_idx + 1;
        end else begin
          hold_pending = 1'b1;
          held = {o_m_data, o_m_sof, o_m_eof};
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic pulse_buf();
    i_buf_ready = 1'b1;
    tick();
    i_buf_ready = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (o_busy && n < 5000) begin
      tick();
      n++;
    end
    chk(tag, o_busy, 0);
  endtask

  initial begin
    int n, vc, b0;
    reset = 1'b1; i_enable = 1'b1; i_buf_ready = 1'b0;
    tick();
    do_reset();

    // 1: latency, gapless frame, reset state
    chk("rst_valid", o_m_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_addr", o_rd_addr, 0);
    chk("rst_frames", o_frame_cnt, 0);
    chk("rst_drops", o_drop_cnt, 0);
    chk("rst_overrun", o_overrun, 0);
    b0 = beats_seen;
    i_buf_ready = 1'b1;
    n = 0;
    while (!o_m_valid && n < 20) begin
      tick();
      i_buf_ready = 1'b0;
      n++;
    end
    chk("t1_latency", n, 3);
    vc = 1;
    n = 0;
    while (o_busy && n < 2000) begin
      tick();
      n++;
      if (o_m_valid) vc++;
    end
    chk("t1_valid_cycles", vc, DEPTH);
    chk("t1_beats", beats_seen - b0, DEPTH);
    chk("t1_frames", o_frame_cnt, 1);
    chk("t1_busy", o_busy, 0);
    chk("t1_addr", o_rd_addr, 0);

    // 2: random backpressure
    do_reset();
    salt = 15'($urandom);
    rnd_ready = 1'b1;
    b0 = beats_seen;
    pulse_buf();
    wait_idle("t2_timeout");
    rnd_ready = 1'b0;
    chk("t2_beats", beats_seen - b0, DEPTH);
    chk("t2_frames", o_frame_cnt, 1);
    chk("t2_overrun", o_overrun, 0);

    // 3: overrun mid-frame
    do_reset();
    salt = 15'($urandom);
    b0 = beats_seen;
    pulse_buf();
    n = 0;
    while (beats_seen - b0 < 200 && n < 2000) begin
      tick();
      n++;
    end
    chk("t3_reach200", beats_seen - b0 >= 200, 1);
    pulse_buf();
    wait_idle("t3_timeout");
    repeat (30) tick();
    chk("t3_overrun", o_overrun, 1);
    chk("t3_drops", o_drop_cnt, 1);
    chk("t3_beats", beats_seen - b0, DEPTH);
    chk("t3_frames", o_frame_cnt, 1);
    chk("t3_no_restart", o_busy, 0);

    // 4: disabled drop, then enabled frame
    do_reset();
    i_enable = 1'b0;
    pulse_buf();
    repeat (10) tick();
    chk("t4_idle", o_busy, 0);
    chk("t4_drops", o_drop_cnt, 1);
    chk("t4_overrun", o_overrun, 0);
    i_enable = 1'b1;
    salt = 15'($urandom);
    b0 = beats_seen;
    pulse_buf();
    wait_idle("t4_timeout");
    chk("t4_beats", beats_seen - b0, DEPTH);
    chk("t4_frames", o_frame_cnt, 1);

    // 5: held level gives one frame; level through reset gives none; reset mid-frame
    do_reset();
    b0 = beats_seen;
    i_buf_ready = 1'b1;
    repeat (1000) tick();
    chk("t5_frames_held", o_frame_cnt, 1);
    chk("t5_beats_held", beats_seen - b0, DEPTH);
    do_reset();
    repeat (20) tick();
    chk("t5_level_thru_reset", o_busy, 0);
    i_buf_ready = 1'b0;
    tick();
    b0 = beats_seen;
    pulse_buf();
    n = 0;
    while (beats_seen - b0 < 100 && n < 2000) begin
      tick();
      n++;
    end
    reset = 1'b1;
    tick();
    chk("t5_rst_valid", o_m_valid, 0);
    chk("t5_rst_busy", o_busy, 0);
    chk("t5_rst_addr", o_rd_addr, 0);
    chk("t5_rst_frames", o_frame_cnt, 0);
    chk("t5_rst_drops", o_drop_cnt, 0);
    reset = 1'b0;

    // 6: three frames spaced 600 cycles
    do_reset();
    salt = 15'($urandom);
    b0 = beats_seen;
    for (int f = 0; f < 3; f++) begin
      pulse_buf();
      repeat (599) tick();
    end
    wait_idle("t6_timeout");
    chk("t6_frames", o_frame_cnt, 3);
    chk("t6_overrun", o_overrun, 0);
    chk("t6_drops", o_drop_cnt, 0);
    chk("t6_beats", beats_seen - b0, 3 * DEPTH);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
